// File: rtl/otter_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per clock,
// with a one-cycle path for divide-by-zero and signed overflow. Optional flush port: MULDIV_FLUSH_EN.
module otter_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
`ifdef MULDIV_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d, done_q, done_d, zero_q, zero_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               flush_c, accept_c, ovf_c, fast_c, sa_c, sb_c, last_c;
  logic [WIDTH-1:0]   fast_res_c, mul_add_c, hi_n_c, lo_n_c, rem_fix_c, final_res_c;
  logic [WIDTH:0]     mul_sum_c, rem_sh_c;
  logic [2*WIDTH-1:0] prod_fix_c;

`ifdef MULDIV_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  assign accept_c   = start && !flush_c && (state_q != CALC);
  assign ovf_c      = !op[0] && (srcA == MIN_NEG) && (srcB == {WIDTH{1'b1}});
  assign fast_c     = op[2] && ((srcB == '0) || ovf_c);
  assign fast_res_c = (srcB == '0) ? (op[1] ? srcA : {WIDTH{1'b1}})
                                   : (op[1] ? '0 : srcA);
  assign sa_c   = srcA[WIDTH-1] && (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
  assign sb_c   = srcB[WIDTH-1] && (op == 3'b001 || op == 3'b100 || op == 3'b110);
  assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

  // One iteration: multiply keeps {hi,lo} as the product, divide keeps hi=remainder, lo=quotient.
  always_comb begin
    mul_add_c = lo_q[0] ? opb_q : '0;
    mul_sum_c = {1'b0, hi_q} + {1'b0, mul_add_c};
    rem_sh_c  = {hi_q, lo_q[WIDTH-1]};
    hi_n_c    = hi_q;
    lo_n_c    = lo_q;
    if (op_q[2]) begin
      if (rem_sh_c >= {1'b0, opb_q}) begin
        hi_n_c = WIDTH'(rem_sh_c - {1'b0, opb_q});
        lo_n_c = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_n_c = rem_sh_c[WIDTH-1:0];
        lo_n_c = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {hi_n_c, lo_n_c} = {mul_sum_c, lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction: the full product is negated so MULH* get the right borrow into the high half.
  always_comb begin
    prod_fix_c = neg_q ? -{hi_n_c, lo_n_c} : {hi_n_c, lo_n_c};
    rem_fix_c  = neg_q ? -hi_n_c : hi_n_c;
    case (op_q)
      3'b000, 3'b100, 3'b101: final_res_c = prod_fix_c[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: final_res_c = prod_fix_c[2*WIDTH-1:WIDTH];
      default:                final_res_c = rem_fix_c;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CALC: begin
        if (flush_c)     state_d = IDLE;
        else if (last_c) state_d = DONE;
      end
      default: begin
        if (accept_c) state_d = fast_c ? DONE : CALC;
        else          state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    zero_d   = zero_q;
    busy_d   = (state_d == CALC);
    done_d   = (state_d == DONE);
    case (state_q)
      CALC: begin
        if (!flush_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          hi_d  = hi_n_c;
          lo_d  = lo_n_c;
          if (last_c) begin
            result_d = final_res_c;
            zero_d   = (final_res_c == '0);
          end
        end
      end
      default: begin
        if (accept_c) begin
          op_d  = op;
          neg_d = (op == 3'b110) ? sa_c : (sa_c ^ sb_c);
          hi_d  = '0;
          lo_d  = sa_c ? -srcA : srcA;
          opb_d = sb_c ? -srcB : srcB;
          cnt_d = '0;
          if (fast_c) begin
            result_d = fast_res_c;
            zero_d   = (fast_res_c == '0);
          end
        end
      end
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_otter_muldiv.sv
// Scoreboard bench for otter_muldiv: expected results and completion cycles are queued at issue
// and checked by an independent done monitor.
module tb_otter_muldiv;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srcA, srcB;
  logic        busy, done, zero;
  logic [31:0] result;
`ifdef MULDIV_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  otter_muldiv dut (
    .CLK(CLK), .RST(RST),
`ifdef MULDIV_FLUSH_EN
    .flush(flush),
`endif
    .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RISC-V M-extension semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sbv;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (o)
      3'b000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'b001: begin p = 64'(sa * sbv); return p[63:32]; end
      3'b010: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = 64'(sa / sbv); return p[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = 64'(sa % sbv); return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done must match the oldest queued expectation, including its cycle.
  always @(negedge CLK) begin
    if (!RST && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("zero", 32'(zero), 32'(e.res == 32'd0));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    exp_t e;
    e.res = exp;
    e.cyc = cyc + (is_fast(o, a, b) ? 1 : 33);
    sb.push_back(e);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(posedge CLK); #2;
    start = 1'b0;
  endtask

  task automatic drain(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 80; i++) begin
      if (busy) nbusy++;
      if (sb.size() == 0) return;
      @(posedge CLK); #2;
    end
    chk("done_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    int nb;
    issue(o, a, b, exp);
    drain(nb);
    chk("busy_cycles", 32'(nb), is_fast(o, a, b) ? 32'd0 : 32'd32);
  endtask

  task automatic idle_watch(input int n);
    int nb;
    nb = 0;
    repeat (n) begin
      @(posedge CLK); #2;
      if (busy) nb++;
    end
    chk("idle_busy", 32'(nb), 32'd0);
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; op = '0; srcA = '0; srcB = '0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);

    run(3'b000, 32'd7, 32'd6, 32'h0000_002A);
    run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run(3'b101, 32'd100, 32'd7, 32'd14);
    run(3'b111, 32'd100, 32'd7, 32'd2);
    run(3'b101, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
    run(3'b110, 32'h1234_5678, 32'd0, 32'h1234_5678);
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

    // Reset in the middle of a calculation: abort, clear outputs, no done.
    start = 1'b1; op = 3'b000; srcA = 32'd9; srcB = 32'd9;
    @(posedge CLK); #2 start = 1'b0;
    repeat (10) @(posedge CLK);
    #2 RST = 1'b1;
    sb.delete();
    @(posedge CLK); #2 RST = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_zero", 32'(zero), 32'd1);
    idle_watch(40);

    // start held through CALC with changing operands, then re-accepted from DONE.
    begin
      exp_t e;
      int nb;
      start = 1'b1; op = 3'b000; srcA = 32'd3; srcB = 32'd5;
      e.res = 32'd15; e.cyc = cyc + 33; sb.push_back(e);
      e.res = 32'd1_000_000; e.cyc = cyc + 66; sb.push_back(e);
      @(posedge CLK); #2;
      srcA = 32'd1000; srcB = 32'd1000;
      repeat (33) @(posedge CLK);
      #2 start = 1'b0;
      drain(nb);
      chk("b2b_busy_cycles", 32'(nb), 32'd32);
    end

`ifdef MULDIV_FLUSH_EN
    run(3'b000, 32'd7, 32'd6, 32'h0000_002A);
    start = 1'b1; op = 3'b000; srcA = 32'd5; srcB = 32'd5;
    @(posedge CLK); #2 start = 1'b0;
    repeat (5) @(posedge CLK);
    #2 flush = 1'b1;
    @(posedge CLK); #2 flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_result", result, 32'h0000_002A);
    idle_watch(40);
    chk("flush_result_held", result, 32'h0000_002A);
`endif

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run(o, a, b, model(o, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
